iob_gpio_in_filter: RTL

Input conditioning stage placed directly upstream of the GPIO peripheral's `gpio_input` port. Each pad bit is synchronised into `clk`, debounced by a per-bit stability counter, and presented as `gpio_filtered`, which drives `gpio_input`. Filtered rising and falling edges set sticky, per-bit interrupt status flags, and their OR forms a single interrupt line to the CPU.

---
 rtl/iob_gpio_in_filter.sv | 85 ++++++++
 1 files changed

// File: rtl/iob_gpio_in_filter.sv
// GPIO input conditioning: two-flop synchroniser, per-bit debounce counter,
// and sticky per-bit edge-event status OR-reduced into a single interrupt.
module iob_gpio_in_filter #(
  parameter int GPIO_W = 32,
  parameter int DEB_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [GPIO_W-1:0] pad_in,
  input  logic [DEB_W-1:0]  deb_cycles,
  input  logic [GPIO_W-1:0] rise_en,
  input  logic [GPIO_W-1:0] fall_en,
  input  logic [GPIO_W-1:0] irq_clr,
  output logic [GPIO_W-1:0] gpio_filtered,
  output logic [GPIO_W-1:0] irq_status,
  output logic              irq
);

  logic [GPIO_W-1:0] r_s1;
  logic [GPIO_W-1:0] r_s2;
  logic [GPIO_W-1:0] r_filt;
  logic [GPIO_W-1:0] r_status;
  logic [DEB_W-1:0]  r_cnt [GPIO_W];

  logic [DEB_W-1:0]  w_last;
  logic [GPIO_W-1:0] w_diff;
  logic [GPIO_W-1:0] w_update;
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_fall;

  // A threshold of 0 behaves as 1, so the last allowed count is never negative.
  assign w_last = (deb_cycles == '0) ? '0 : deb_cycles - DEB_W'(1);
  assign w_diff = r_s2 ^ r_filt;

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    w_update = '0;
    for (int i = 0; i < GPIO_W; i++) begin
      w_update[i] = w_diff[i] && (r_cnt[i] >= w_last);
    end
  end

  assign w_rise = w_update &  r_s2 & rise_en;
  assign w_fall = w_update & ~r_s2 & fall_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pad_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_filt   <= '0;
      r_status <= '0;
      // NOTE: the counter array is a bank of flops, not a RAM, so it takes the async reset too.
      for (int i = 0; i < GPIO_W; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // Set has priority over clear when both land on the same edge.
      r_status <= (r_status & ~irq_clr) | w_rise | w_fall;
      for (int i = 0; i < GPIO_W; i++) begin
        if (!w_diff[i]) begin
          r_cnt[i] <= '0;
        end else if (w_update[i]) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign gpio_filtered = r_filt;
  assign irq_status    = r_status;
  assign irq           = |r_status;

endmodule
